// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the step-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_e;

  // One radix-4 step per two bits of the (WIDTH+2)-bit extended operand
  function automatic int booth_steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window to digit,
// 2M select and negate flag.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] win_i,
  output digit_e     digit_o,
  output logic       sel2_o,
  output logic       neg_o
);

  always_comb begin
    digit_o = ZERO;
    unique case (win_i)
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
  end

  assign sel2_o = (digit_o == POS2) || (digit_o == NEG2);
  assign neg_o  = (digit_o == NEG1) || (digit_o == NEG2);

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// Optional early termination under BOOTH_EARLY_TERM_EN.
module booth_r4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int E  = WIDTH + 2;
  localparam int AW = E + 2;
  localparam int PW = AW + E + 1;
  localparam int RW = 2 * WIDTH;
  localparam int N  = booth_steps(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   m_q, m_d;
  logic [RW-1:0]   result_q, result_d;

  digit_e          digit;
  logic            sel2;
  logic            neg;
  logic [AW-1:0]   a_hi;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   pp_x;
  logic [AW-1:0]   sum;
  logic signed [PW-1:0] cat;
  logic [PW-1:0]   stepped;
  logic            last;
  logic            finish;
  logic [RW-1:0]   fin_res;
  logic [E-1:0]    q_ext;
  logic [AW-1:0]   m_ext;

  booth_r4_encoder u_enc (
    .win_i   (acc_q[2:0]),
    .digit_o (digit),
    .sel2_o  (sel2),
    .neg_o   (neg)
  );

  // Accumulator layout: {A[AW-1:0], Q[E-1:0], q_-1}
  assign a_hi = acc_q[PW-1 -: AW];

  always_comb begin
    pp = '0;
    if (digit != ZERO) begin
      pp = sel2 ? {m_q[AW-2:0], 1'b0} : m_q;
    end
  end

  assign pp_x    = neg ? ~pp : pp;
  assign sum     = a_hi + pp_x + {{(AW-1){1'b0}}, neg};
  assign cat     = {sum, acc_q[E:0]};
  assign stepped = cat >>> 2;
  assign last    = (cnt_q == CW'(N - 1));

`ifdef BOOTH_EARLY_TERM_EN
  localparam int SW = $clog2(E + 1);

  logic [CW-1:0]          rem;
  logic [SW-1:0]          sh;
  logic [E-1:0]           mask;
  logic                   et_hit;
  logic signed [PW-2:0]   ps;

  // Remaining windows see only copies of one bit: all digits are zero
  assign rem     = CW'(N - 1) - cnt_q;
  assign sh      = SW'({rem, 1'b0});
  assign mask    = (E'(1) << sh) - E'(1);
  assign et_hit  = ((stepped[E:1] ^ {E{stepped[0]}}) & mask) == '0;
  assign ps      = stepped[PW-1:1];
  assign fin_res = RW'(ps >>> sh);
  assign finish  = last | et_hit;
`else
  assign fin_res = stepped[RW:1];
  assign finish  = last;
`endif

  assign q_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};
  assign m_ext = signed_mode ? {{4{multiplicand[WIDTH-1]}}, multiplicand}
                             : {4'b0000, multiplicand};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      acc_d    = '0;
      result_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op_start) begin
            state_d  = EXEC;
            cnt_d    = '0;
            acc_d    = {{AW{1'b0}}, q_ext, 1'b0};
            m_d      = m_ext;
            result_d = '0;
          end
        end
        EXEC: begin
          acc_d = stepped;
          cnt_d = cnt_q + 1'b1;
          if (finish) begin
            state_d  = DONE;
            result_d = fin_res;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == EXEC);
  assign op_done = (state_q == DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier (WIDTH=64).
// Latency expectations follow BOOTH_EARLY_TERM_EN when defined.
module tb_booth_r4_multiplier;

  localparam int W = 64;
  localparam int N = W / 2 + 1;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           op_start;
  logic           op_clear;
  logic           signed_mode;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic           busy;
  logic           op_done;
  logic [2*W-1:0] result;

  int n_chk;
  int n_fail;
  logic [2*W-1:0] sb_q[$];

  typedef struct {
    bit           sm;
    logic [W-1:0] q;
    logic [W-1:0] m;
    logic [127:0] exp;
    int           et_lat;
  } vec_t;

  vec_t vecs[$];

  booth_r4_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .signed_mode  (signed_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .op_done      (op_done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model(input bit sm, input logic [W-1:0] q,
                                         input logic [W-1:0] m);
    logic signed [127:0] a;
    logic signed [127:0] b;
    if (sm) begin
      a = {{64{q[W-1]}}, q};
      b = {{64{m[W-1]}}, m};
    end else begin
      a = {64'b0, q};
      b = {64'b0, m};
    end
    return a * b;
  endfunction

  function automatic vec_t mk(input bit sm, input logic [W-1:0] q,
                              input logic [W-1:0] m, input logic [127:0] exp,
                              input int et_lat);
    vec_t v;
    v.sm = sm;
    v.q = q;
    v.m = m;
    v.exp = exp;
    v.et_lat = et_lat;
    return v;
  endfunction

  // mid > 0: pulse op_start with foreign operands that many edges in
  task automatic run_op(input vec_t v, input int mid);
    int lat;
    int el;
    logic [127:0] exp;
    @(negedge clk);
    signed_mode  = v.sm;
    multiplier   = v.q;
    multiplicand = v.m;
    op_start     = 1'b1;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    op_start   = 1'b0;
    multiplier = ~v.q;
    check("busy_after_start", {127'b0, busy}, 128'd1);
    lat = 0;
    while (!op_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (mid > 0 && lat == mid) begin
        op_start     = 1'b1;
        multiplicand = ~v.m;
        signed_mode  = ~v.sm;
      end else begin
        op_start = 1'b0;
      end
    end
    op_start = 1'b0;
    check("done_seen", {127'b0, op_done}, 128'd1);
    el = ET ? v.et_lat : N;
    if (el > 0) check("latency", 128'(lat), 128'(el));
    else check("latency_range", {127'b0, (lat >= 1 && lat <= N)}, 128'd1);
    exp = sb_q.pop_front();
    check("result", result, exp);
    @(negedge clk);
    op_start     = 1'b1;
    multiplier   = '1;
    multiplicand = '1;
    signed_mode  = ~v.sm;
    @(negedge clk);
    op_start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_hold", {127'b0, op_done}, 128'd1);
    check("result_hold", result, exp);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    check("clear_done", {127'b0, op_done}, 128'd0);
    check("clear_result", result, 128'd0);
  endtask

  initial begin
    logic [W-1:0] rq;
    logic [W-1:0] rm;
    bit rs;
    int lat;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    op_start = 1'b0;
    op_clear = 1'b0;
    signed_mode = 1'b0;
    multiplier = '0;
    multiplicand = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_done", {127'b0, op_done}, 128'd0);
    check("rst_result", result, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs.push_back(mk(1'b0, '1, '1,
      128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0));
    vecs.push_back(mk(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
      128'h4000_0000_0000_0000_0000_0000_0000_0000, 0));
    vecs.push_back(mk(1'b1, '1, '1, 128'd1, 1));
    vecs.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
      {{120{1'b1}}, 8'hEB}, 0));
    vecs.push_back(mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
      128'h0000_0000_0000_0006_FFFF_FFFF_FFFF_FFEB, 0));
    vecs.push_back(mk(1'b1, 64'd5, 64'd3, 128'd15, 2));
    vecs.push_back(mk(1'b1, '1, 64'd3, {{124{1'b1}}, 4'hD}, 1));
    vecs.push_back(mk(1'b0, 64'd0, 64'hDEAD_BEEF_0000_0001, 128'd0, 1));
    vecs.push_back(mk(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
      model(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000), 0));
    for (int i = 0; i < 6; i++) begin
      rq = {$urandom, $urandom};
      rm = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      vecs.push_back(mk(rs, rq, rm, model(rs, rq, rm), 0));
    end

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0);

    run_op(mk(1'b1, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321,
      model(1'b1, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321), 0), 3);

    // Abort at step 10 with a competing op_start
    @(negedge clk);
    signed_mode = 1'b1;
    multiplier = 64'h5555_AAAA_1234_8765;
    multiplicand = 64'h0F0F_F0F0_7777_1111;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    op_clear = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    check("abort_busy", {127'b0, busy}, 128'd0);
    check("abort_done", {127'b0, op_done}, 128'd0);
    check("abort_result", result, 128'd0);
    @(posedge clk);
    #1;
    check("abort_no_start", {127'b0, busy}, 128'd0);
    run_op(mk(1'b0, 64'd3, 64'd5, 128'd15, 0), 0);

    // Async reset mid-operation
    @(negedge clk);
    signed_mode = 1'b0;
    multiplier = 64'hC3C3_0000_FFFF_1357;
    multiplicand = 64'h2468_ACE0_1111_9999;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {127'b0, busy}, 128'd0);
    check("rst_mid_done", {127'b0, op_done}, 128'd0);
    check("rst_mid_result", result, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_idle_busy", {127'b0, busy}, 128'd0);
    check("rst_idle_done", {127'b0, op_done}, 128'd0);

    // Async reset while holding a result
    @(negedge clk);
    signed_mode = 1'b1;
    multiplier = 64'd9;
    multiplicand = 64'd7;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    lat = 0;
    while (!op_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("pre_rst_result", result, 128'd63);
    #2;
    reset = 1'b1;
    #1;
    check("rst_hold_done", {127'b0, op_done}, 128'd0);
    check("rst_hold_result", result, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_multiplier.md
# booth_r4_multiplier

Parametrised sequential radix-4 Booth multiplier, the next generation of our radix-2 iterative multiplier. It takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, with signed or unsigned operation selected per operation. It retires two multiplier bits per cycle and keeps the op_start / op_clear / op_done handshake. It sits behind the datapath's multi-cycle execute stage.

## Interface
- WIDTH, 64, operand width; must be even and ≥ 4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op_start  in  1  starts an operation; sampled only in IDLE
- op_clear  in  1  synchronous abort/clear; returns the block to IDLE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with op_start
- multiplier  in  WIDTH  operand Q; latched with op_start
- multiplicand  in  WIDTH  operand M; latched with op_start
- busy  out  1  high in EXEC
- op_done  out  1  high in DONE
- result  out  2*WIDTH  product; valid while op_done is high

## Operation
- Internal operand width is E = WIDTH+2. Operands are sign-extended when signed_mode=1 and zero-extended when signed_mode=0.
- Step count N = E/2 = WIDTH/2+1. For WIDTH=64, N=33.
- States:
  - IDLE: waits for op_start.
  - EXEC: one radix-4 step per cycle.
  - DONE: holds result.
- Transitions:
  - IDLE→EXEC on op_start.
  - EXEC→DONE after the N-th step.
  - DONE stays in DONE until op_clear.
  - Any state → IDLE on op_clear.
- op_clear has priority over op_start in the same cycle.
- op_start outside IDLE is ignored. Operands are not re-sampled.
- Each step forms a Booth digit from multiplier bits (q[2i+1], q[2i], q[2i-1]), with q[-1]=0. The digit is in {−2,−1,0,+1,+2}. The step adds digit×M into the upper accumulator half, then arithmetic-shifts the accumulator right by 2. The accumulator is E+2 bits wide so that ±2M cannot overflow.
- result = the low 2*WIDTH bits of the final product. This is exact for both modes.
- Reset values: state=IDLE, busy=0, op_done=0, result=0, step counter=0.
- op_clear zeroes result, the accumulator and the counter on the next edge.

## Timing
- op_start high at edge E0 in IDLE: busy is high from E0 and steps execute on edges E1..EN.
- After edge EN: busy=0, op_done=1, result valid.
- Fixed latency is N cycles from the op_start edge to op_done, i.e. 33 cycles for WIDTH=64.
- op_done and result are held indefinitely until op_clear.
- A new op_start is accepted the cycle after op_clear has returned the block to IDLE. It is not accepted in the same edge as op_clear.
- reset mid-operation forces the reset values immediately, with no edge required.

## Configuration
- BOOTH_EARLY_TERM_EN defined:
  - After each step, if all remaining multiplier bits plus the overlap bit are equal (all-0 or all-1), every remaining digit is zero.
  - The block then jumps to DONE on that edge, applying the remaining shift in one operation.
  - result is bit-identical to the fixed-latency path; latency is between 1 and N cycles.
- BOOTH_EARLY_TERM_EN undefined:
  - Latency is always exactly N.
  - No early-termination compare logic is present.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, EXEC, DONE);
  - the Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2);
  - a function returning N for a given WIDTH.
- Sub-module booth_r4_encoder maps a 3-bit multiplier window to a digit, plus a partial-product select and a negate flag.
- The top module holds the FSM, the counter, the accumulator and the adder.

## Test plan
- WIDTH=64, signed_mode=0, Q=M=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; op_done rises exactly 33 cycles after op_start (macro off).
- signed_mode=1, Q=M=0x8000_0000_0000_0000 (−2^63) → result 0x4000_0000_0000_0000_0000_0000_0000_0000. signed_mode=1, Q=−1, M=−1 → result 1.
- signed_mode=1, Q=−3, M=7 → result −21 (0xFFFF…FFEB). Same operands with signed_mode=0 → result 0x0000_0000_0000_0006_FFFF_FFFF_FFFF_FFEB.
- op_clear at step 10 with op_start high in the same cycle → next cycle IDLE, busy=0, result=0. A subsequent op_start with 3×5 → 15 after 33 cycles.
- reset asserted at step 20 → busy, op_done and result are 0 immediately. After release, the block remains IDLE until op_start.
- BOOTH_EARLY_TERM_EN defined, signed_mode=1, Q=5, M=3 → result 15 with op_done after 2 cycles. Q=−1 → op_done after 1 cycle with result −3. Randomised operands match the macro-off result.
